// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and helpers for the data-memory controller.
//   mem_size_t   : request access size encoding (byte/half/word/reserved)
//   ctrl_state_t : controller state (INIT sweep / RUN)
//   DATA_W, BYTES: data word width and byte lanes per word
//   extend_load  : picks the addressed lane(s) out of a memory word and
//                  sign- or zero-extends them to a full data word
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BYTES  = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

    // Little-endian lane select: byte uses lane[1:0], half uses lane[1]
    // (lane[0] is already known to be 0 for a legal half access).
    function automatic logic [DATA_W-1:0] extend_load(
        input mem_size_t         size,
        input logic              is_unsigned,
        input logic [1:0]        lane,
        input logic [DATA_W-1:0] word
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// dmem_rsp_pipe
// Fixed-latency response pipeline: RD_LAT stages of valid/data/err.
// Stage 0 captures the response computed at the accept edge; the last stage
// drives the response port, so a response appears RD_LAT cycles after accept.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_rdata/in_err : response produced at the accept edge
//   out_valid/out_rdata/out_err : delayed response to the requester
module dmem_rsp_pipe
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic              in_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err
);

    logic              valid_q [RD_LAT];
    logic [DATA_W-1:0] data_q  [RD_LAT];
    logic              err_q   [RD_LAT];

    // Shift register; reset drops every in-flight response at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                err_q[i]   <= 1'b0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_rdata;
            err_q[0]   <= in_err;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_rdata = data_q[RD_LAT-1];
    assign out_err   = err_q[RD_LAT-1];

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl
// Single-port byte-addressed data memory for the MIPS datapath with a
// valid/ready request port and a fixed-latency pipelined response.
// Optional feature macro: DMEM_INIT_CLEAR_EN -- after reset the INIT state
// sweeps zeros through every word before requests are accepted.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake (ready only in RUN)
//   req_we            : 1 = store, 0 = load
//   req_size          : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned      : zero-extend sub-word loads when 1
//   req_addr          : little-endian byte address
//   req_wdata         : right-aligned store data
//   rsp_valid/rdata/err : one response per accepted request, RD_LAT later
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    ctrl_state_t       state_q, state_d;
    mem_size_t         size;
    logic [IDX_W-1:0]  word_idx;
    logic              accept;
    logic              range_err, size_err, align_err, acc_err;
    logic              store_we;
    logic [BYTES-1:0]  wr_be;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] pipe_rdata;
    logic              sweep_we;
    logic [IDX_W-1:0]  sweep_idx;

    assign size     = mem_size_t'(req_size);
    assign word_idx = req_addr[IDX_W+1:2];
    assign accept   = req_valid && req_ready;

    // Access checks are evaluated on the request as presented at the accept edge.
    assign range_err = req_addr >= ADDR_W'(DEPTH * BYTES);
    assign size_err  = (size == SZ_RSVD);
    assign align_err = ((size == SZ_HALF) && req_addr[0]) ||
                       ((size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign acc_err   = range_err || size_err || align_err;
    assign store_we  = accept && req_we && !acc_err;

`ifdef DMEM_INIT_CLEAR_EN
    // One extra count bit: the sweep writes words 0..DEPTH-1 and the state
    // leaves INIT on the cycle after the counter has wrapped into bit IDX_W.
    logic [CNT_W-1:0] sweep_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_cnt <= '0;
        end else if (sweep_we) begin
            sweep_cnt <= sweep_cnt + CNT_W'(1);
        end
    end

    assign sweep_idx = sweep_cnt[IDX_W-1:0];
`else
    assign sweep_idx = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: INIT holds for the sweep when enabled, otherwise one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
`ifdef DMEM_INIT_CLEAR_EN
                if (sweep_cnt == CNT_W'(DEPTH)) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // State outputs.
    always_comb begin
        req_ready = (state_q == ST_RUN);
`ifdef DMEM_INIT_CLEAR_EN
        sweep_we  = (state_q == ST_INIT) && !sweep_cnt[IDX_W];
`else
        sweep_we  = 1'b0;
`endif
    end

    // Store lane enables; data is replicated so each lane sees its own byte.
    always_comb begin
        wr_be   = '0;
        wr_data = req_wdata;
        case (size)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            SZ_WORD: wr_be = 4'b1111;
            default: wr_be = '0;
        endcase
    end

    // RAM array has no reset so contents survive rst_n; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_idx] <= '0;
        end else if (store_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Load data is read from the array before the accept edge, so a load
    // directly behind a store sees the already committed word.
    assign load_data  = extend_load(size, req_unsigned, req_addr[1:0], mem[word_idx]);
    assign pipe_rdata = (accept && !req_we && !acc_err) ? load_data : '0;

    dmem_rsp_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rsp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_rdata  (pipe_rdata),
        .in_err    (accept && acc_err),
        .out_valid (rsp_valid),
        .out_rdata (rsp_rdata),
        .out_err   (rsp_err)
    );

endmodule
